// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle multiply/divide unit: radix-2 shift-add multiply, restoring divide, sign fix-up.
// Optional macro MULDIV_EARLY_OUT_EN: trivially-known results (x/0, overflow, x*0) finish in one cycle.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic             Stall,
  output logic [WIDTH-1:0] Result
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     result_q, result_d;

  // Operand decode and magnitude capture in IDLE
  logic             a_sgn_in, b_sgn_in, a_neg_in, b_neg_in, is_div_in;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;
  logic             neg_in;

  always_comb begin
    is_div_in = Funct3[2];
    a_sgn_in  = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                (Funct3 == 3'b100) || (Funct3 == 3'b110);
    b_sgn_in  = (Funct3 == 3'b000) || (Funct3 == 3'b001) ||
                (Funct3 == 3'b100) || (Funct3 == 3'b110);
    a_neg_in  = a_sgn_in & SrcA[WIDTH-1];
    b_neg_in  = b_sgn_in & SrcB[WIDTH-1];
    a_mag_in  = a_neg_in ? (WIDTH'(0) - SrcA) : SrcA;
    b_mag_in  = b_neg_in ? (WIDTH'(0) - SrcB) : SrcB;
    if (!is_div_in) begin
      neg_in = a_neg_in ^ b_neg_in;
    end else if (!Funct3[1]) begin
      neg_in = (a_neg_in ^ b_neg_in) & (SrcB != '0);
    end else begin
      neg_in = a_neg_in;
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic             early_hit;
  logic [WIDTH-1:0] early_val;
  logic             b_zero_in, ovf_in;

  always_comb begin
    early_hit = 1'b0;
    early_val = '0;
    b_zero_in = (SrcB == '0);
    ovf_in    = Funct3[2] & ~Funct3[0] &
                (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) & (SrcB == {WIDTH{1'b1}});
    if (Funct3[2]) begin
      if (b_zero_in) begin
        early_hit = 1'b1;
        early_val = Funct3[1] ? SrcA : {WIDTH{1'b1}};
      end else if (ovf_in) begin
        early_hit = 1'b1;
        early_val = Funct3[1] ? '0 : SrcA;
      end
    end else if ((SrcA == '0) || b_zero_in) begin
      early_hit = 1'b1;
      early_val = '0;
    end
  end
`endif

  // acc holds {product hi, product lo / multiplier} or {remainder, dividend / quotient}
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic                 div_ok;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   div_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ok    = (div_shift >= {1'b0, opnd_q});
    // Partial remainder is always below the divisor, so the difference fits in WIDTH bits
    div_rem   = div_shift[WIDTH-1:0] - opnd_q;
    div_next  = {(div_ok ? div_rem : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ok};
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_val;

  always_comb begin
    prod_fix = neg_q ? ((2*WIDTH)'(0) - acc_q) : acc_q;
    quo_fix  = neg_q ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    rem_fix  = neg_q ? (WIDTH'(0) - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
    case (op_q)
      3'b000:                 fix_val = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_val = quo_fix;
      default:                fix_val = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    result_d = result_q;
    if (Flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            op_d    = Funct3;
            opnd_d  = is_div_in ? b_mag_in : a_mag_in;
            acc_d   = {{WIDTH{1'b0}}, (is_div_in ? a_mag_in : b_mag_in)};
            neg_d   = neg_in;
            cnt_d   = '0;
            state_d = CALC;
`ifdef MULDIV_EARLY_OUT_EN
            if (early_hit) begin
              result_d = early_val;
              state_d  = DONE;
            end
`endif
          end
        end
        CALC: begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_d = FIX;
          end
        end
        FIX: begin
          result_d = fix_val;
          state_d  = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign Busy   = (state_q != IDLE);
  assign Done   = (state_q == DONE);
  assign Stall  = Start & ~Done;
  assign Result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer (WIDTH=32) against a plain-arithmetic model.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, Start, Flush;
  logic [2:0]   Funct3;
  logic [W-1:0] SrcA, SrcB, Result;
  logic         Busy, Done, Stall;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] last_res;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Start  (Start),
    .Funct3 (Funct3),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .Flush  (Flush),
    .Busy   (Busy),
    .Done   (Done),
    .Stall  (Stall),
    .Result (Result)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RV32M semantics from 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, ua, ub, q;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = sa / sb; return q[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        q = ua / ub; return q[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb; return q[31:0];
      end
      default: begin
        if (b == 0) return a;
        q = ua % ub; return q[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2]) return (b == 0) || ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (a == 0) || (b == 0);
  endfunction

  // Edges counted from the capturing edge up to the edge that raises Done
  function automatic int exp_lat(input bit special);
    int lat;
    lat = W + 2;
`ifdef MULDIV_EARLY_OUT_EN
    if (special) lat = 1;
`endif
    return lat;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Called 1 time unit after a rising edge with the block idle
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int cyc;
    bit stall_ok, busy_ok, special;
    special = is_special(f3, a, b);
    Funct3 = f3; SrcA = a; SrcB = b; Start = 1'b1;
    #1;
    check_eq("stall_on_start", Stall, 1);
    cyc = 0; stall_ok = 1; busy_ok = 1;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (!Done) begin
        if (!Stall) stall_ok = 0;
        if (!Busy) busy_ok = 0;
      end
    end while (!Done && cyc < 200);
    check_eq("done_seen", Done, 1);
    check_eq("latency", cyc, exp_lat(special));
    check_eq("stall_low_on_done", Stall, 0);
    check_eq("stall_busy_held", {stall_ok, busy_ok}, 2'b11);
    check_eq("result", Result, exp);
    $display("op f3=%0d a=%h b=%h special=%0b result=%h exp=%h lat=%0d",
             f3, a, b, special, Result, exp, cyc);
    Start = 1'b0;
    @(posedge clk); #1;
    check_eq("done_single_pulse", Done, 0);
    check_eq("idle_after_done", Busy, 0);
    check_eq("result_held", Result, exp);
    last_res = exp;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    bit          saw_done;

    rst_n = 1'b0; Start = 1'b0; Flush = 1'b0; Funct3 = '0; SrcA = '0; SrcB = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_busy", Busy, 0);
    check_eq("reset_done", Done, 0);
    check_eq("reset_result", Result, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd100, 32'd7, 32'd14);
    run_op(3'd7, 32'd100, 32'd7, 32'd2);
    run_op(3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF);
    run_op(3'd6, 32'h1234, 32'd0, 32'h1234);
    run_op(3'd4, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF);
    run_op(3'd6, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    run_op(3'd0, 32'd0, 32'd12345, 32'd0);

    // Flush ten cycles into a divide
    Funct3 = 3'd4; SrcA = 32'd100; SrcB = 32'd7; Start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    Flush = 1'b1; Start = 1'b0;
    @(posedge clk); #1;
    Flush = 1'b0;
    check_eq("flush_busy", Busy, 0);
    check_eq("flush_done", Done, 0);
    check_eq("flush_result", Result, last_res);
    saw_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (Done) saw_done = 1;
    end
    check_eq("flush_no_done", saw_done, 0);
    $display("flush mid-DIV busy=%0b result=%h", Busy, Result);
    run_op(3'd0, 32'd3, 32'd4, 32'd12);

    // Start coincident with Flush in IDLE is dropped
    Funct3 = 3'd0; SrcA = 32'd5; SrcB = 32'd6; Start = 1'b1; Flush = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; Flush = 1'b0;
    check_eq("flush_blocks_start", Busy, 0);
    $display("flush with start busy=%0b", Busy);
    @(posedge clk); #1;

    // Reset mid-CALC with Start held through it
    Funct3 = 3'd0; SrcA = 32'd5; SrcB = 32'd6; Start = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    Funct3 = 3'd3; SrcA = 32'hFFFF_FFFF; SrcB = 32'd2;
    @(posedge clk); #1;
    check_eq("midreset_busy", Busy, 0);
    check_eq("midreset_done", Done, 0);
    check_eq("midreset_result", Result, 0);
    check_eq("midreset_stall", Stall, 1);
    $display("reset mid-CALC busy=%0b result=%h", Busy, Result);
    rst_n = 1'b1;
    run_op(3'd3, 32'hFFFF_FFFF, 32'd2, 32'd1);

    for (int i = 0; i < 60; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = pick_operand();
      run_op(rf3, ra, rb, ref_result(rf3, ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
